mc_ctrl_irq: RTL

- Parametrised multicycle MIPS control FSM: decodes opcode/funct/rs and sequences fetch, decode, execute, memory, writeback and interrupt-check states.
- Generalises the single-irq controller with NUM_IRQ maskable, priority-encoded interrupt lines, memory wait-states and reserved-instruction exceptions.
- Sits between the IR/CP0 and the datapath muxes and enables; drives PC, register file, data memory and CP0 write strobes.

---
 rtl/mc_ctrl_irq_pkg.sv | 104 ++++++++++
 rtl/mc_ctrl_irq_prio_enc.sv | 26 ++
 rtl/mc_ctrl_irq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_irq_pkg.sv
// +--------------------------------------------------------------------------+
// | mc_ctrl_pkg : opcodes, state encodings, mux selects and the decoder      |
// | Rev 1.0     : initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_COP0  = 6'b010000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_ERET  = 6'b011000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [4:0] RS_MF    = 5'b00000;
    localparam logic [4:0] RS_MT    = 5'b00100;
    localparam logic [4:0] RS_CO    = 5'b10000;

    localparam logic [3:0] S_IF  = 4'd0;
    localparam logic [3:0] S_ID  = 4'd1;
    localparam logic [3:0] S_EXA = 4'd2;
    localparam logic [3:0] S_MEM = 4'd3;
    localparam logic [3:0] S_WBL = 4'd4;
    localparam logic [3:0] S_EXB = 4'd5;
    localparam logic [3:0] S_EXR = 4'd6;
    localparam logic [3:0] S_WBR = 4'd7;
    localparam logic [3:0] S_INT = 4'd8;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] ALU_SLT  = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] JMP_VEC  = 2'b10;
    localparam logic [1:0] JMP_EPC  = 2'b11;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_LINK  = 2'b10;
    localparam logic [1:0] WB_CP0   = 2'b11;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_RI   = 5'd10;

    typedef struct packed {
        logic addu, subu, slt, jr, jalr, j, jal, beq;
        logic addi, addiu, ori, lui, lw, sw, lb, sb;
        logic mfc0, mtc0, eret, rsvd;
    } instr_t;

    function automatic instr_t decode(input logic [5:0] op, input logic [5:0] funct,
                                      input logic [4:0] rs);
        instr_t d;
        d       = '0;
        d.addu  = (op == OP_RTYPE) && (funct == FN_ADDU);
        d.subu  = (op == OP_RTYPE) && (funct == FN_SUBU);
        d.slt   = (op == OP_RTYPE) && (funct == FN_SLT);
        d.jr    = (op == OP_RTYPE) && (funct == FN_JR);
        d.jalr  = (op == OP_RTYPE) && (funct == FN_JALR);
        d.j     = (op == OP_J);
        d.jal   = (op == OP_JAL);
        d.beq   = (op == OP_BEQ);
        d.addi  = (op == OP_ADDI);
        d.addiu = (op == OP_ADDIU);
        d.ori   = (op == OP_ORI);
        d.lui   = (op == OP_LUI);
        d.lw    = (op == OP_LW);
        d.sw    = (op == OP_SW);
        d.lb    = (op == OP_LB);
        d.sb    = (op == OP_SB);
        d.mfc0  = (op == OP_COP0) && (rs == RS_MF);
        d.mtc0  = (op == OP_COP0) && (rs == RS_MT);
        d.eret  = (op == OP_COP0) && (rs == RS_CO) && (funct == FN_ERET);
        // rsvd is still 0 here, so this reads "no known instruction matched"
        d.rsvd  = ~(|d);
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_irq_prio_enc.sv
// +--------------------------------------------------------------------------+
// | prio_enc : lowest-index-first priority encoder with valid flag           |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module prio_enc #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [2:0]       o_idx,
    output logic             o_valid
);

    always_comb begin
        o_idx   = 3'd0;
        o_valid = |i_req;
        // Scan downwards so the lowest set index is the one left standing
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = 3'(i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl_irq.sv
// +--------------------------------------------------------------------------+
// | mc_ctrl_irq : multicycle MIPS control FSM with prioritised interrupts    |
// | Rev 1.0     : initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mc_ctrl_irq
    import mc_ctrl_pkg::*;
#(
    parameter int NUM_IRQ  = 6,
    parameter bit MEM_WAIT = 1'b1,
    parameter bit RI_EXC   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic [4:0]         rs,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] im,
    input  logic               ie,
    input  logic               exl,
    input  logic               mem_ready,
    output logic               pc_wr,
    output logic               npc_sel,
    output logic               alu_src,
    output logic               reg_wr,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               cp0_wr,
    output logic               exl_set,
    output logic               exl_clr,
    output logic               sb,
    output logic               lb,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         ext_op,
    output logic [1:0]         alu_ctr,
    output logic [1:0]         jump,
    output logic [4:0]         exc_code,
    output logic [2:0]         irq_id,
    output logic [3:0]         state
);

    logic [3:0]         r_state;
    logic [3:0]         w_next;
    logic               r_ri;
    instr_t             w_d;
    logic               w_mem_ok;
    logic               w_ri;
    logic               w_jmp;
    logic               w_take;
    logic [NUM_IRQ-1:0] w_pend;
    logic [2:0]         w_idx;
    logic               w_valid;

    assign w_d      = decode(op, funct, rs);
    assign w_mem_ok = mem_ready | !MEM_WAIT;
    assign w_ri     = RI_EXC && w_d.rsvd;
    assign w_jmp    = w_d.j | w_d.jal | w_d.jr | w_d.jalr | w_d.eret;
    assign w_pend   = irq & im;
    assign w_take   = r_ri | (w_valid & ie & !exl);
    assign state    = r_state;

    prio_enc #(.WIDTH(NUM_IRQ)) u_prio (
        .i_req   (w_pend),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IF;
            r_ri    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID)       r_ri <= w_ri;
            else if (r_state == S_INT) r_ri <= 1'b0;
        end
    end

    always_comb begin
        w_next     = r_state;
        pc_wr      = 1'b0;
        npc_sel    = 1'b0;
        alu_src    = 1'b0;
        reg_wr     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        cp0_wr     = 1'b0;
        exl_set    = 1'b0;
        exl_clr    = 1'b0;
        sb         = 1'b0;
        lb         = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALU;
        ext_op     = EXT_ZERO;
        alu_ctr    = ALU_ADD;
        jump       = 2'b00;
        exc_code   = EXC_INT;
        irq_id     = 3'd0;
        // Outputs stay quiet while reset is held, even though the state is IF
        if (!rst) begin
            case (r_state)
                S_IF: begin
                    mem_rd = 1'b1;
                    pc_wr  = w_mem_ok;
                    if (w_mem_ok) w_next = S_ID;
                end
                S_ID: begin
                    if (w_ri) begin
                        w_next = S_INT;
                    end else begin
                        jump    = w_d.eret ? JMP_EPC : {w_d.jr | w_d.jalr, w_d.j | w_d.jal};
                        reg_wr  = w_d.jal | w_d.jalr;
                        reg_dst = w_d.jal ? DST_RA : (w_d.jalr ? DST_RD : DST_RT);
                        mem_to_reg = (w_d.jal | w_d.jalr) ? WB_LINK : WB_ALU;
                        exl_clr = w_d.eret;
                        pc_wr   = w_jmp;
                        if (w_jmp)                                    w_next = S_INT;
                        else if (w_d.lw | w_d.sw | w_d.lb | w_d.sb)   w_next = S_EXA;
                        else if (w_d.beq)                             w_next = S_EXB;
                        else                                          w_next = S_EXR;
                    end
                end
                S_EXA: begin
                    alu_src = 1'b1;
                    ext_op  = EXT_SIGN;
                    alu_ctr = ALU_ADD;
                    w_next  = S_MEM;
                end
                S_MEM: begin
                    mem_rd = w_d.lw | w_d.lb;
                    mem_wr = (w_d.sw | w_d.sb) & w_mem_ok;
                    sb     = w_d.sb;
                    lb     = w_d.lb;
                    if (w_mem_ok) w_next = (w_d.lw | w_d.lb) ? S_WBL : S_INT;
                end
                S_WBL: begin
                    reg_wr     = 1'b1;
                    reg_dst    = DST_RT;
                    mem_to_reg = WB_MEM;
                    lb         = w_d.lb;
                    w_next     = S_INT;
                end
                S_EXB: begin
                    npc_sel = 1'b1;
                    alu_ctr = ALU_SUB;
                    w_next  = S_INT;
                end
                S_EXR: begin
                    alu_src = w_d.addi | w_d.addiu | w_d.ori | w_d.lui;
                    ext_op  = w_d.lui ? EXT_LUI : ((w_d.addi | w_d.addiu) ? EXT_SIGN : EXT_ZERO);
                    alu_ctr = w_d.subu ? ALU_SUB : (w_d.slt ? ALU_SLT : (w_d.ori ? ALU_OR : ALU_ADD));
                    cp0_wr  = w_d.mtc0;
                    w_next  = S_WBR;
                end
                S_WBR: begin
                    reg_wr     = w_d.addu | w_d.subu | w_d.slt | w_d.addi | w_d.addiu |
                                 w_d.ori | w_d.lui | w_d.mfc0;
                    reg_dst    = (w_d.addu | w_d.subu | w_d.slt) ? DST_RD : DST_RT;
                    mem_to_reg = w_d.mfc0 ? WB_CP0 : WB_ALU;
                    w_next     = S_INT;
                end
                S_INT: begin
                    if (w_take) begin
                        pc_wr    = 1'b1;
                        jump     = JMP_VEC;
                        exl_set  = 1'b1;
                        exc_code = r_ri ? EXC_RI : EXC_INT;
                        irq_id   = r_ri ? 3'd0 : w_idx;
                    end
                    w_next = S_IF;
                end
                default: w_next = S_IF;
            endcase
        end
    end

endmodule

`default_nettype wire
